cpu_trace_buffer: RTL

CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

---
 rtl/cpu_trace_buffer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cpu_trace_buffer.sv
// CPU execution trace buffer: records one entry per opcode fetch into a ring,
// either stopping when full or running until a PC trigger plus a post-trigger window.
module cpu_trace_buffer #(
    parameter int DATA_W    = 48,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     capture_stb,
    input  logic [DATA_W-1:0]        capture_data,
    input  logic                     arm,
    input  logic                     mode,
    input  logic                     trig_en,
    input  logic [15:0]              trig_pc,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state,
    output logic                     overflow,
    output logic                     trig_seen
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_C  = AW'(POST_TRIG);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        POST    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [AW-1:0]     post_cnt_q, post_cnt_d;
    logic              overflow_q, overflow_d;
    logic              trig_seen_q, trig_seen_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              wr_en_s;
    logic              full_s;
    logic              pc_match_s;
    logic              rd_valid_s;
    logic              rd_fire_s;

    assign full_s     = (count_q == DEPTH_C);
    assign pc_match_s = (capture_data[DATA_W-1 -: 16] == trig_pc);
    assign rd_valid_s = ((state_q == IDLE) || (state_q == DONE)) && (count_q != '0);
    assign rd_fire_s  = rd_valid_s && rd_ready;

    // Next-state, pointer and flag computation
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        post_cnt_d  = post_cnt_q;
        overflow_d  = overflow_q;
        trig_seen_d = trig_seen_q;
        wr_en_s     = 1'b0;
        if (arm) begin
            state_d     = CAPTURE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            post_cnt_d  = '0;
            overflow_d  = 1'b0;
            trig_seen_d = 1'b0;
        end else begin
            case (state_q)
                CAPTURE, POST: begin
                    if (capture_stb && full_s && !mode) begin
                        // Only reachable if mode flipped to 0 on a full ring: drop and stop
                        overflow_d = 1'b1;
                        state_d    = DONE;
                    end else if (capture_stb) begin
                        wr_en_s  = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (full_s) begin
                            rd_ptr_d   = rd_ptr_q + 1'b1;
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                        if (state_q == POST) begin
                            post_cnt_d = post_cnt_q - 1'b1;
                            if (post_cnt_q == {{(AW-1){1'b0}}, 1'b1}) begin
                                state_d = DONE;
                            end else begin
                                state_d = POST;
                            end
                        end else if (mode && trig_en && pc_match_s) begin
                            trig_seen_d = 1'b1;
                            post_cnt_d  = POST_C;
                            state_d     = (POST_TRIG == 0) ? DONE : POST;
                        end else begin
                            state_d = state_q;
                        end
                        if (!mode && (count_q == DEPTH_C - 1'b1)) begin
                            state_d = DONE;
                        end else begin
                            overflow_d = overflow_d;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                IDLE, DONE: begin
                    if (rd_fire_s) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        count_d  = count_q - 1'b1;
                    end else begin
                        count_d = count_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            trig_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            post_cnt_q  <= post_cnt_d;
            overflow_q  <= overflow_d;
            trig_seen_q <= trig_seen_d;
        end
    end

    // Trace storage, left unreset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= capture_data;
        end
    end

    assign rd_valid  = rd_valid_s;
    assign rd_data   = rd_valid_s ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign state     = state_q;
    assign overflow  = overflow_q;
    assign trig_seen = trig_seen_q;

endmodule
